// File: rtl/yazmac_obegi.sv
// Integer register file with per-register pending table; writeback port updates data, decode allocates tags.
// Optional macro YAZMAC_ATLAMA_EN: read ports bypass a same-cycle matching writeback.
module yazmac_obegi #(
   parameter int VERI_BIT   = 32,
   parameter int YAZMAC_BIT = 5,
   parameter int ETIKET_BIT = 4
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  ayir_gecerli_i,
   input  logic [YAZMAC_BIT-1:0] ayir_adres_i,
   input  logic [ETIKET_BIT-1:0] ayir_etiket_i,
   input  logic                  yo_gecerli_i,
   input  logic [VERI_BIT-1:0]   yo_veri_i,
   input  logic [YAZMAC_BIT-1:0] yo_adres_i,
   input  logic [ETIKET_BIT-1:0] yo_etiket_i,
   input  logic                  temizle_i,
   input  logic [YAZMAC_BIT-1:0] rs1_adres_i,
   output logic [VERI_BIT-1:0]   rs1_veri_o,
   output logic                  rs1_hazir_o,
   output logic [ETIKET_BIT-1:0] rs1_etiket_o,
   input  logic [YAZMAC_BIT-1:0] rs2_adres_i,
   output logic [VERI_BIT-1:0]   rs2_veri_o,
   output logic                  rs2_hazir_o,
   output logic [ETIKET_BIT-1:0] rs2_etiket_o
);

   localparam int N = 2 ** YAZMAC_BIT;

   logic [VERI_BIT-1:0]   veri_q    [N];
   logic [VERI_BIT-1:0]   veri_d    [N];
   logic [ETIKET_BIT-1:0] etiket_q  [N];
   logic [ETIKET_BIT-1:0] etiket_d  [N];
   logic [N-1:0]          bekliyor_q;
   logic [N-1:0]          bekliyor_d;

   logic                  yo_aktif;
   logic                  ayir_aktif;
   logic                  yo_eslesme;

   assign yo_aktif   = yo_gecerli_i && (yo_adres_i != '0);
   assign ayir_aktif = ayir_gecerli_i && (ayir_adres_i != '0);
   assign yo_eslesme = yo_aktif && bekliyor_q[yo_adres_i]
                       && (etiket_q[yo_adres_i] == yo_etiket_i);

   // Allocation is applied after writeback so it wins on the same register.
   always_comb begin
      veri_d     = veri_q;
      etiket_d   = etiket_q;
      bekliyor_d = bekliyor_q;
      if (yo_aktif) begin
         veri_d[yo_adres_i] = yo_veri_i;
      end
      if (yo_eslesme) begin
         bekliyor_d[yo_adres_i] = 1'b0;
      end
      if (temizle_i) begin
         bekliyor_d = '0;
      end else if (ayir_aktif) begin
         bekliyor_d[ayir_adres_i] = 1'b1;
         etiket_d[ayir_adres_i]   = ayir_etiket_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < N; i++) begin
            veri_q[i]   <= '0;
            etiket_q[i] <= '0;
         end
         bekliyor_q <= '0;
      end else begin
         veri_q     <= veri_d;
         etiket_q   <= etiket_d;
         bekliyor_q <= bekliyor_d;
      end
   end

   logic [YAZMAC_BIT-1:0] oku_adres  [2];
   logic [VERI_BIT-1:0]   oku_veri   [2];
   logic                  oku_hazir  [2];
   logic [ETIKET_BIT-1:0] oku_etiket [2];

   assign oku_adres[0] = rs1_adres_i;
   assign oku_adres[1] = rs2_adres_i;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         oku_veri[p]   = veri_q[oku_adres[p]];
         oku_hazir[p]  = 1'b1;
         oku_etiket[p] = '0;
         if (oku_adres[p] == '0) begin
            oku_veri[p] = '0;
         end else if (bekliyor_q[oku_adres[p]]) begin
`ifdef YAZMAC_ATLAMA_EN
            if (yo_eslesme && (yo_adres_i == oku_adres[p])) begin
               oku_veri[p] = yo_veri_i;
            end else begin
               oku_hazir[p]  = 1'b0;
               oku_etiket[p] = etiket_q[oku_adres[p]];
            end
`else
            oku_hazir[p]  = 1'b0;
            oku_etiket[p] = etiket_q[oku_adres[p]];
`endif
         end
      end
   end

   assign rs1_veri_o   = oku_veri[0];
   assign rs1_hazir_o  = oku_hazir[0];
   assign rs1_etiket_o = oku_etiket[0];
   assign rs2_veri_o   = oku_veri[1];
   assign rs2_hazir_o  = oku_hazir[1];
   assign rs2_etiket_o = oku_etiket[1];

endmodule
